// File: rtl/tone_pkg.sv
// Shared types and constants for the tone player: FSM state encoding,
// note codes, the per-note half-period table and the song ROM geometry.
package tone_pkg;

   // Encoding is visible on the mode output, so values are fixed.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StManual = 2'd1,
      StPlay   = 2'd2,
      StGap    = 2'd3
   } state_e;

   localparam int unsigned SONG_LEN = 32;
   localparam int unsigned SONG_AW  = 5;

   // Note codes: 0 is rest, 1-7 low octave C..B, 8-14 middle octave C..B.
   localparam logic [3:0] NOTE_REST  = 4'd0;
   localparam logic [3:0] NOTE_LOW_C = 4'd1;
   localparam logic [3:0] NOTE_LOW_D = 4'd2;
   localparam logic [3:0] NOTE_LOW_E = 4'd3;
   localparam logic [3:0] NOTE_LOW_F = 4'd4;
   localparam logic [3:0] NOTE_LOW_G = 4'd5;
   localparam logic [3:0] NOTE_LOW_A = 4'd6;
   localparam logic [3:0] NOTE_LOW_B = 4'd7;
   localparam logic [3:0] NOTE_MID_C = 4'd8;
   localparam logic [3:0] NOTE_MID_D = 4'd9;
   localparam logic [3:0] NOTE_MID_E = 4'd10;
   localparam logic [3:0] NOTE_MID_F = 4'd11;
   localparam logic [3:0] NOTE_MID_G = 4'd12;
   localparam logic [3:0] NOTE_MID_A = 4'd13;
   localparam logic [3:0] NOTE_MID_B = 4'd14;

   // Half-period counts at 50 MHz: round(25e6 / f_note), indexed by note code.
   localparam logic [16:0] DIV_HALF_TAB [15] = '{
      17'd0,
      17'd95556, 17'd85132, 17'd75843, 17'd71586, 17'd63776, 17'd56818, 17'd50620,
      17'd47778, 17'd42566, 17'd37922, 17'd35793, 17'd31888, 17'd28409, 17'd25310
   };

   // Table lookup; codes outside the table map to silence.
   function automatic logic [16:0] div_half_of(input logic [3:0] code);
      logic [16:0] val;
      val = '0;
      if (code <= NOTE_MID_B) val = DIV_HALF_TAB[code];
      return val;
   endfunction

endpackage

// File: rtl/tone_song_rom.sv
// Song storage: 32 entries of {note[3:0], dur[1:0]}; dur 0 marks the end.
module tone_song_rom
   import tone_pkg::*;
(
   input  logic [SONG_AW-1:0] addr,
   output logic [5:0]         entry
);

   // Combinational lookup; unused slots hold end markers.
   always_comb begin
      entry = {NOTE_REST, 2'd0};
      unique case (addr)
         5'd0:    entry = {NOTE_LOW_C, 2'd2};
         5'd1:    entry = {NOTE_LOW_C, 2'd1};
         5'd2:    entry = {NOTE_LOW_G, 2'd1};
         5'd3:    entry = {NOTE_LOW_G, 2'd1};
         5'd4:    entry = {NOTE_LOW_A, 2'd1};
         5'd5:    entry = {NOTE_LOW_A, 2'd1};
         5'd6:    entry = {NOTE_LOW_G, 2'd2};
         5'd7:    entry = {NOTE_REST,  2'd1};
         5'd8:    entry = {NOTE_LOW_F, 2'd1};
         5'd9:    entry = {NOTE_LOW_F, 2'd1};
         5'd10:   entry = {NOTE_LOW_E, 2'd1};
         5'd11:   entry = {NOTE_LOW_E, 2'd1};
         5'd12:   entry = {NOTE_LOW_D, 2'd1};
         5'd13:   entry = {NOTE_LOW_D, 2'd1};
         5'd14:   entry = {NOTE_MID_C, 2'd3};
         default: entry = {NOTE_REST,  2'd0};
      endcase
   end

endmodule

// File: rtl/tone_play_sched.sv
// Tone scheduler: manual keys take priority over an auto-played song.
// Everything downstream sees registered outputs derived from next state.
module tone_play_sched
   import tone_pkg::*;
#(
   parameter int unsigned BEAT_DIV = 12_500_000,
   parameter int unsigned GAP_DIV  = 1_250_000
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               auto,
   input  logic [13:0]        Key,
   output logic [3:0]         tone_code,
   output logic               tone_en,
   output logic [16:0]        div_half,
   output logic [6:0]         low,
   output logic [6:0]         middle,
   output logic [1:0]         mode,
   output logic [SONG_AW-1:0] song_pos,
   output logic               song_done
);

   localparam int unsigned BW = $clog2(3 * BEAT_DIV);
   localparam int unsigned GW = (GAP_DIV > 1) ? $clog2(GAP_DIV) : 1;

   logic              auto_m, auto_s;
   logic [13:0]       key_m, key_s;
   state_e            state_q, state_d;
   logic [SONG_AW-1:0] pos_q, pos_d;
   logic [BW-1:0]     beat_q, beat_d, beat_last;
   logic [GW-1:0]     gap_q, gap_d, gap_last;
   logic [1:0]        dur_q;
   logic              resume_gap_q, resume_gap_d;
   logic [3:0]        code_d, key_idx;
   logic              en_d, done_d, key_any;
   logic [6:0]        low_d, mid_d;
   logic [5:0]        nxt_entry;

   // The ROM is addressed with the next position so the note registers with
   // its state; dur_q therefore always holds the duration of entry pos_q.
   tone_song_rom u_song_rom (
      .addr  (pos_d),
      .entry (nxt_entry)
   );

   // Two-flop synchronisers for the asynchronous auto and key inputs.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         auto_m <= 1'b0;
         auto_s <= 1'b0;
         key_m  <= '0;
         key_s  <= '0;
      end else begin
         auto_m <= auto;
         auto_s <= auto_m;
         key_m  <= Key;
         key_s  <= key_m;
      end
   end

   // Lowest pressed key wins.
   always_comb begin
      key_idx = 4'd0;
      for (int i = 13; i >= 0; i--) begin
         if (key_s[i]) key_idx = 4'(i);
      end
   end

   assign key_any   = |key_s;
   assign beat_last = BW'(32'(dur_q) * BEAT_DIV - 1);
   assign gap_last  = GW'(GAP_DIV - 1);

   // Next-state: keys preempt with all song counters frozen.
   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      beat_d       = beat_q;
      gap_d        = gap_q;
      resume_gap_d = resume_gap_q;
      done_d       = 1'b0;
      if (key_any) begin
         state_d = StManual;
         if (state_q != StManual) resume_gap_d = (state_q == StGap);
      end else begin
         unique case (state_q)
            StIdle: begin
               if (auto_s) begin
                  state_d = StPlay;
                  pos_d   = '0;
                  beat_d  = '0;
                  gap_d   = '0;
               end
            end
            StManual: begin
               if (auto_s) begin
                  state_d = resume_gap_q ? StGap : StPlay;
               end else begin
                  state_d = StIdle;
                  pos_d   = '0;
                  beat_d  = '0;
                  gap_d   = '0;
               end
            end
            StPlay: begin
               if (!auto_s) begin
                  state_d = StIdle;
                  pos_d   = '0;
                  beat_d  = '0;
                  gap_d   = '0;
               end else if (dur_q == 2'd0) begin
                  // End marker: wrap straight into entry 0 with no gap.
                  pos_d  = '0;
                  beat_d = '0;
                  done_d = 1'b1;
               end else if (beat_q == beat_last) begin
                  state_d = StGap;
                  beat_d  = '0;
                  gap_d   = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
            StGap: begin
               if (!auto_s) begin
                  state_d = StIdle;
                  pos_d   = '0;
                  beat_d  = '0;
                  gap_d   = '0;
               end else if (gap_q == gap_last) begin
                  state_d = StPlay;
                  gap_d   = '0;
                  pos_d   = pos_q + 1'b1;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Output values for the upcoming state, so they register alongside it.
   always_comb begin
      code_d = NOTE_REST;
      en_d   = 1'b0;
      low_d  = '0;
      mid_d  = '0;
      unique case (state_d)
         StManual: begin
            code_d = key_idx + 4'd1;
            en_d   = 1'b1;
         end
         StPlay: begin
            code_d = nxt_entry[5:2];
            en_d   = (code_d != NOTE_REST) && (nxt_entry[1:0] != 2'd0);
         end
         default: ;
      endcase
      if (code_d >= NOTE_LOW_C && code_d <= NOTE_LOW_B) begin
         low_d[3'(code_d - NOTE_LOW_C)] = 1'b1;
      end else if (code_d >= NOTE_MID_C && code_d <= NOTE_MID_B) begin
         mid_d[3'(code_d - NOTE_MID_C)] = 1'b1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         pos_q        <= '0;
         beat_q       <= '0;
         gap_q        <= '0;
         dur_q        <= '0;
         resume_gap_q <= 1'b0;
         tone_code    <= '0;
         tone_en      <= 1'b0;
         div_half     <= '0;
         low          <= '0;
         middle       <= '0;
         song_done    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         beat_q       <= beat_d;
         gap_q        <= gap_d;
         dur_q        <= nxt_entry[1:0];
         resume_gap_q <= resume_gap_d;
         tone_code    <= code_d;
         tone_en      <= en_d;
         div_half     <= div_half_of(code_d);
         low          <= low_d;
         middle       <= mid_d;
         song_done    <= done_d;
      end
   end

   assign mode     = state_q;
   assign song_pos = pos_q;

endmodule

// File: tb/tb_tone_play_sched.sv
// Directed bench for tone_play_sched with short beat and gap periods.
module tb_tone_play_sched;

   logic        clk_in = 1'b0;
   logic        rst    = 1'b1;
   logic        auto   = 1'b0;
   logic [13:0] Key    = '0;
   logic [3:0]  tone_code;
   logic        tone_en;
   logic [16:0] div_half;
   logic [6:0]  low;
   logic [6:0]  middle;
   logic [1:0]  mode;
   logic [4:0]  song_pos;
   logic        song_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [13:0] key;
      logic [3:0]  code;
      logic [6:0]  low;
      logic [6:0]  mid;
      logic [16:0] div;
   } vec_t;

   vec_t vecs [8];

   tone_play_sched #(
      .BEAT_DIV (8),
      .GAP_DIV  (2)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .auto      (auto),
      .Key       (Key),
      .tone_code (tone_code),
      .tone_en   (tone_en),
      .div_half  (div_half),
      .low       (low),
      .middle    (middle),
      .mode      (mode),
      .song_pos  (song_pos),
      .song_done (song_done)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [4:0] prev;

      vecs[0] = '{14'h0180, 4'd8,  7'h00, 7'h01, 17'd47778};
      vecs[1] = '{14'h0002, 4'd2,  7'h02, 7'h00, 17'd85132};
      vecs[2] = '{14'h0040, 4'd7,  7'h40, 7'h00, 17'd50620};
      vecs[3] = '{14'h2000, 4'd14, 7'h00, 7'h40, 17'd25310};
      vecs[4] = '{14'h3000, 4'd13, 7'h00, 7'h20, 17'd28409};
      vecs[5] = '{14'h0014, 4'd3,  7'h04, 7'h00, 17'd75843};
      vecs[6] = '{14'h0800, 4'd12, 7'h00, 7'h10, 17'd31888};
      vecs[7] = '{14'h0008, 4'd4,  7'h08, 7'h00, 17'd71586};

      // Reset state
      #2 rst = 1'b0;
      #1;
      chk("rst_mode", mode, 0);
      chk("rst_en", tone_en, 0);
      chk("rst_code", tone_code, 0);
      chk("rst_div", div_half, 0);
      chk("rst_leds", {low, middle}, 0);
      chk("rst_pos", song_pos, 0);
      repeat (2) @(posedge clk_in);
      #1 rst = 1'b1;
      tick(2);

      // Key latency: nothing after 2 edges, note after exactly 3
      Key = 14'h0001;
      tick(2);
      chk("lat2_en", tone_en, 0);
      chk("lat2_mode", mode, 0);
      tick(1);
      chk("lat3_code", tone_code, 1);
      chk("lat3_en", tone_en, 1);
      chk("lat3_div", div_half, 95556);
      chk("lat3_low", low, 7'h01);
      chk("lat3_mode", mode, 1);
      tick(17);
      chk("hold_code", tone_code, 1);
      Key = '0;
      tick(3);
      chk("rel_mode", mode, 0);
      chk("rel_en", tone_en, 0);
      chk("rel_code", tone_code, 0);

      // Manual key table
      for (int i = 0; i < 8; i++) begin
         Key = vecs[i].key;
         tick(3);
         chk($sformatf("v%0d_code", i), tone_code, vecs[i].code);
         chk($sformatf("v%0d_en", i), tone_en, 1);
         chk($sformatf("v%0d_low", i), low, vecs[i].low);
         chk($sformatf("v%0d_mid", i), middle, vecs[i].mid);
         chk($sformatf("v%0d_div", i), div_half, vecs[i].div);
         chk($sformatf("v%0d_mode", i), mode, 1);
         Key = '0;
         tick(3);
         chk($sformatf("v%0d_off", i), tone_en, 0);
      end

      // Auto play: entry 0 is two beats then a two-cycle gap
      auto = 1'b1;
      tick(3);
      chk("ap_mode", mode, 2);
      chk("ap_pos", song_pos, 0);
      chk("ap_code", tone_code, 1);
      n = 0;
      while (tone_en === 1'b1 && n < 100) begin
         n++;
         tick(1);
      end
      chk("ap_on_cycles", n, 16);
      n = 0;
      while (tone_en === 1'b0 && n < 100) begin
         n++;
         tick(1);
      end
      chk("ap_gap_cycles", n, 2);
      chk("ap_pos1", song_pos, 1);
      chk("ap_mode_play", mode, 2);

      // Auto drop returns to idle once synchronised
      auto = 1'b0;
      tick(2);
      chk("drop_early", mode, 2);
      tick(1);
      chk("drop_mode", mode, 0);
      chk("drop_pos", song_pos, 0);
      chk("drop_en", tone_en, 0);

      // Preempt at beat 5 of entry 0, then resume
      auto = 1'b1;
      tick(3);
      chk("pre_start", mode, 2);
      tick(3);
      Key = 14'h0010;
      tick(3);
      chk("pre_mode", mode, 1);
      chk("pre_code", tone_code, 5);
      chk("pre_low", low, 7'h10);
      chk("pre_pos", song_pos, 0);
      tick(2);
      Key = '0;
      tick(3);
      chk("res_mode", mode, 2);
      chk("res_pos", song_pos, 0);
      chk("res_code", tone_code, 1);
      n = 0;
      while (tone_en === 1'b1 && n < 100) begin
         n++;
         tick(1);
      end
      chk("res_remaining", n, 11);
      chk("res_gap", mode, 3);

      // Run to the end marker
      n = 0;
      prev = song_pos;
      while (song_done !== 1'b1 && n < 600) begin
         prev = song_pos;
         n++;
         tick(1);
      end
      chk("end_done", song_done, 1);
      chk("end_prev_pos", prev, 15);
      chk("end_pos0", song_pos, 0);
      chk("end_code", tone_code, 1);
      chk("end_en", tone_en, 1);
      tick(1);
      chk("end_one_cycle", song_done, 0);
      chk("end_still_play", mode, 2);

      // Asynchronous reset mid-note
      chk("mid_note_en", tone_en, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_en", tone_en, 0);
      chk("arst_code", tone_code, 0);
      chk("arst_div", div_half, 0);
      chk("arst_leds", {low, middle}, 0);
      chk("arst_mode", mode, 0);
      chk("arst_pos", song_pos, 0);
      chk("arst_done", song_done, 0);
      #2 rst = 1'b1;
      tick(2);
      chk("rs_idle", mode, 0);
      tick(1);
      chk("rs_play", mode, 2);
      chk("rs_pos", song_pos, 0);
      chk("rs_en", tone_en, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
